// File: rtl/hazard_sched_if.sv
// Pipeline <-> hazard controller signal bundle: register numbers, stage controls,
// and the stall/flush/forward/MDU outputs.
interface hazard_sched_if;
    logic [4:0] RsD, RtD, RsE, RtE;
    logic [4:0] WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW;
    logic       MemtoRegE, MemtoRegM;
    logic       BranchD, PCSrcD, JumpD;
    logic       MdStartD, MdDivD, MdReadD;
    logic       StallF, StallD, FlushD, FlushE;
    logic       ForwardAD, ForwardBD;
    logic [1:0] ForwardAE, ForwardBE;
    logic       MdBusy, MdDone;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, PCSrcD, JumpD, MdStartD, MdDivD, MdReadD,
        input  StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD,
               ForwardAE, ForwardBE, MdBusy, MdDone
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, PCSrcD, JumpD, MdStartD, MdDivD, MdReadD,
        output StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD,
               ForwardAE, ForwardBE, MdBusy, MdDone
    );
endinterface

// File: rtl/hazard_sched_unit.sv
// Hazard controller for the 5-stage MIPS pipeline: stall/flush generation,
// operand forwarding and scheduling of the shared multi-cycle mult/div unit.
module hazard_sched_unit #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic          clk,
    input  logic          reset,
    hazard_sched_if.slave hz
);

    typedef enum logic {RUN, MD_BUSY} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             lwstall, brstall, mdstall, stall, md_done;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] src);
        if (hz.RegWriteM && hit(hz.WriteRegM, src))
            return 2'b10;
        else if (hz.RegWriteW && hit(hz.WriteRegW, src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        lwstall = hz.MemtoRegE & (hit(hz.RtE, hz.RsD) | hit(hz.RtE, hz.RtD));
        brstall = hz.BranchD &
                  ((hz.RegWriteE & (hit(hz.WriteRegE, hz.RsD) | hit(hz.WriteRegE, hz.RtD))) |
                   (hz.MemtoRegM & (hit(hz.WriteRegM, hz.RsD) | hit(hz.WriteRegM, hz.RtD))));
        md_done = (state == MD_BUSY) && (cnt == '0);
        // mfhi/mflo may proceed on the final busy cycle; a new mult/div may not.
        mdstall = (state == MD_BUSY) & (hz.MdStartD | (hz.MdReadD & ~md_done));
        stall   = reset & (lwstall | brstall | mdstall);
    end

    always_comb begin
        hz.StallF    = stall;
        hz.StallD    = stall;
        hz.FlushE    = stall;
        hz.FlushD    = reset & (hz.PCSrcD | hz.JumpD) & ~stall;
        hz.ForwardAD = 1'b0;
        hz.ForwardBD = 1'b0;
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        if (reset) begin
            hz.ForwardAD = hz.RegWriteM & hit(hz.WriteRegM, hz.RsD);
            hz.ForwardBD = hz.RegWriteM & hit(hz.WriteRegM, hz.RtD);
            hz.ForwardAE = fwd_e(hz.RsE);
            hz.ForwardBE = fwd_e(hz.RtE);
        end
        hz.MdBusy = (state == MD_BUSY);
        hz.MdDone = md_done;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            RUN: begin
                if (hz.MdStartD && !stall) begin
                    state_nx = MD_BUSY;
                    cnt_nx   = hz.MdDivD ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
                end
            end
            MD_BUSY: begin
                if (cnt == '0)
                    state_nx = RUN;
                else
                    cnt_nx = cnt - CNT_W'(1);
            end
            default: state_nx = RUN;
        endcase
    end

endmodule

// File: tb/tb_hazard_sched_unit.sv
// Scoreboard bench for hazard_sched_unit: stimulus pushes hand-computed output
// vectors, a monitor process pops and compares them against the DUT.
module tb_hazard_sched_unit;

    logic clk = 1'b0;
    logic reset = 1'b0;
    hazard_sched_if hif();

    hazard_sched_unit #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [11:0] v;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   tests = 0;
    int   fails = 0;

    // {StallF,StallD,FlushD,FlushE,FwdAD,FwdBD,FwdAE,FwdBE,MdBusy,MdDone}
    function automatic logic [11:0] ev(input logic s, input logic fd, input logic fad,
                                       input logic fbd, input logic [1:0] ae,
                                       input logic [1:0] be, input logic busy,
                                       input logic done);
        return {s, s, fd, s, fad, fbd, ae, be, busy, done};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {hif.StallF, hif.StallD, hif.FlushD, hif.FlushE, hif.ForwardAD,
                hif.ForwardBD, hif.ForwardAE, hif.ForwardBE, hif.MdBusy, hif.MdDone};
    endfunction

    initial begin
        exp_t e;
        logic [11:0] act;
        forever begin
            @(chk_ev);
            #1;
            while (q.size() > 0) begin
                e   = q.pop_front();
                act = dut_vec();
                tests++;
                if (act !== e.v) begin
                    fails++;
                    $display("FAIL %s: got %b expected %b", e.name, act, e.v);
                end
            end
        end
    end

    task automatic expect_out(input string name, input logic [11:0] v);
        exp_t e;
        e.name = name;
        e.v    = v;
        q.push_back(e);
        -> chk_ev;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hif.RsD = '0; hif.RtD = '0; hif.RsE = '0; hif.RtE = '0;
        hif.WriteRegE = '0; hif.WriteRegM = '0; hif.WriteRegW = '0;
        hif.RegWriteE = 1'b0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
        hif.MemtoRegE = 1'b0; hif.MemtoRegM = 1'b0;
        hif.BranchD = 1'b0; hif.PCSrcD = 1'b0; hif.JumpD = 1'b0;
        hif.MdStartD = 1'b0; hif.MdDivD = 1'b0; hif.MdReadD = 1'b0;
    endtask

    initial begin
        clear_inputs();
        hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd8; hif.RsE = 5'd8;
        hif.MemtoRegE = 1'b1; hif.RtE = 5'd5; hif.RsD = 5'd5;
        #2;
        expect_out("reset_forced_zero", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tick();
        reset = 1'b1;
        clear_inputs();
        expect_out("idle", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));

        // Load-use hazards
        tick();
        hif.MemtoRegE = 1'b1; hif.RtE = 5'd5; hif.RsD = 5'd5;
        expect_out("lwstall_rs", ev(1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tick();
        hif.MemtoRegE = 1'b0;
        expect_out("lwstall_clear", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        hif.MemtoRegE = 1'b1; hif.RtE = 5'd7; hif.RsD = 5'd0; hif.RtD = 5'd7;
        expect_out("lwstall_rt", ev(1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        hif.RtE = 5'd0; hif.RtD = 5'd0;
        expect_out("lwstall_reg0", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));

        // Forwarding
        clear_inputs();
        hif.RegWriteM = 1'b1; hif.RegWriteW = 1'b1;
        hif.WriteRegM = 5'd8; hif.WriteRegW = 5'd8; hif.RsE = 5'd8;
        expect_out("fwdAE_mem", ev(0, 0, 0, 0, 2'b10, 2'b00, 0, 0));
        hif.RegWriteM = 1'b0;
        expect_out("fwdAE_wb", ev(0, 0, 0, 0, 2'b01, 2'b00, 0, 0));
        hif.RsE = 5'd0; hif.WriteRegW = 5'd0; hif.WriteRegM = 5'd0; hif.RegWriteM = 1'b1;
        expect_out("fwdAE_reg0", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        hif.WriteRegM = 5'd8; hif.RsE = 5'd8; hif.WriteRegW = 5'd9; hif.RtE = 5'd9;
        expect_out("fwd_both_e", ev(0, 0, 0, 0, 2'b10, 2'b01, 0, 0));
        clear_inputs();
        hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd4; hif.RsD = 5'd4; hif.RtD = 5'd4;
        expect_out("fwd_d", ev(0, 0, 1, 1, 2'b00, 2'b00, 0, 0));

        // Branch / jump
        clear_inputs();
        hif.BranchD = 1'b1; hif.PCSrcD = 1'b1;
        expect_out("branch_flush", ev(0, 1, 0, 0, 2'b00, 2'b00, 0, 0));
        hif.RegWriteE = 1'b1; hif.WriteRegE = 5'd3; hif.RsD = 5'd3;
        expect_out("brstall_exe", ev(1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        clear_inputs();
        hif.BranchD = 1'b1; hif.PCSrcD = 1'b1; hif.MemtoRegM = 1'b1;
        hif.WriteRegM = 5'd6; hif.RtD = 5'd6;
        expect_out("brstall_load", ev(1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        clear_inputs();
        hif.JumpD = 1'b1;
        expect_out("jump_flush", ev(0, 1, 0, 0, 2'b00, 2'b00, 0, 0));

        // Divide then mflo, with a taken branch that must not flush while stalled
        tick();
        clear_inputs();
        hif.MdStartD = 1'b1; hif.MdDivD = 1'b1;
        expect_out("div_issue", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        for (int unsigned k = 1; k <= 32; k++) begin
            tick();
            hif.MdStartD = 1'b0; hif.MdDivD = 1'b0; hif.MdReadD = 1'b1; hif.PCSrcD = 1'b1;
            expect_out($sformatf("div_busy_%0d", k),
                       ev(k < 32, k == 32, 0, 0, 2'b00, 2'b00, 1, k == 32));
        end
        tick();
        hif.PCSrcD = 1'b0;
        expect_out("div_after", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));

        // Back-to-back multiplies
        clear_inputs();
        hif.MdStartD = 1'b1;
        expect_out("mul1_issue", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        for (int unsigned k = 1; k <= 4; k++) begin
            tick();
            expect_out($sformatf("mul1_busy_%0d", k), ev(1, 0, 0, 0, 2'b00, 2'b00, 1, k == 4));
        end
        tick();
        expect_out("mul2_issue", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        for (int unsigned k = 1; k <= 4; k++) begin
            tick();
            hif.MdStartD = 1'b0;
            expect_out($sformatf("mul2_busy_%0d", k), ev(0, 0, 0, 0, 2'b00, 2'b00, 1, k == 4));
        end
        tick();
        expect_out("mul2_after", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));

        // Load-use stall blocks an MDU start
        hif.MdStartD = 1'b1; hif.MemtoRegE = 1'b1; hif.RtE = 5'd5; hif.RsD = 5'd5;
        expect_out("lw_vs_mdstart", ev(1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tick();
        clear_inputs();
        expect_out("mdstart_blocked", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));

        // Asynchronous reset mid-divide
        hif.MdStartD = 1'b1; hif.MdDivD = 1'b1;
        expect_out("div2_issue", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        for (int unsigned k = 1; k <= 10; k++) begin
            tick();
            hif.MdStartD = 1'b0; hif.MdDivD = 1'b0; hif.MdReadD = 1'b1;
            hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd8; hif.RsE = 5'd8;
        end
        expect_out("div2_busy_10", ev(1, 0, 0, 0, 2'b10, 2'b00, 1, 0));
        reset = 1'b0;
        expect_out("reset_async", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tick();
        reset = 1'b1;
        expect_out("reset_release", ev(0, 0, 0, 0, 2'b10, 2'b00, 0, 0));
        hif.MdReadD = 1'b0; hif.MdStartD = 1'b1;
        expect_out("mul3_issue", ev(0, 0, 0, 0, 2'b10, 2'b00, 0, 0));
        tick();
        hif.MdStartD = 1'b0; hif.MdReadD = 1'b1;
        expect_out("mul3_accepted", ev(1, 0, 0, 0, 2'b10, 2'b00, 1, 0));

        #5;
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
